// File: rtl/pipelined_memory_pkg.sv
// Shared definitions for the pipelined memory slice: word/memory sizes and the read-port tag.
package pipelined_memory_pkg;

    localparam int WORD_W  = 16;
    localparam int MEM_LEN = 1024;

    localparam int DEFAULT_WIDTH = WORD_W;
    localparam int DEFAULT_DEPTH = MEM_LEN;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

endpackage

// File: rtl/pipelined_memory_read_pipe.sv
// Read delay line: carries valid, port tag and word through LATENCY-1 register stages.
module read_pipe
    import pipelined_memory_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  port_t            tag,
    input  logic [WIDTH-1:0] data,
    output logic             dly_vld,
    output port_t            dly_tag,
    output logic [WIDTH-1:0] dly_data
);

    generate
        if (LATENCY == 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst};
            assign dly_vld   = vld;
            assign dly_tag   = tag;
            assign dly_data  = data;
        end else begin : g_stages
            localparam int N = LATENCY - 1;

            logic             vld_q  [N];
            port_t            tag_q  [N];
            logic [WIDTH-1:0] data_q [N];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < N; i++) vld_q[i] <= 1'b0;
                end else begin
                    vld_q[0] <= vld;
                    for (int i = 1; i < N; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                tag_q[0]  <= tag;
                data_q[0] <= data;
                for (int i = 1; i < N; i++) begin
                    tag_q[i]  <= tag_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end

            assign dly_vld  = vld_q[N-1];
            assign dly_tag  = tag_q[N-1];
            assign dly_data = data_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_memory.sv
// Single-array memory shared by an instruction and a data port, data port has priority.
// Define MEM_RANGE_CHECK_EN to add the addr_err out-of-range pulse output.
module pipelined_memory
    import pipelined_memory_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             instr_req,
    output logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic [WIDTH-1:0] data_addr,
    input  logic             data_req,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic             addr_err
`endif
);

    localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH:0] DEPTH_LIM = (WIDTH+1)'(DEPTH);

    function automatic logic in_range(input logic [WIDTH-1:0] addr);
        return {1'b0, addr} < DEPTH_LIM;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] sel_addr;
    port_t            sel_tag;
    logic             acc, rd, wr, hit;

    // One array access per cycle: the data port wins, the fetch waits.
    assign instr_ready = instr_req & ~data_req;
    assign acc         = data_req | instr_req;
    assign sel_addr    = data_req ? data_addr : pc;
    assign sel_tag     = data_req ? PORT_DATA : PORT_INSTR;
    assign hit         = in_range(sel_addr);
    assign wr          = data_req & write_en & ~rst & hit;
    assign rd          = acc & ~(data_req & write_en);

    always_ff @(posedge clk) begin
        if (wr) mem[sel_addr[AW-1:0]] <= data_in;
    end

    // p0: array sampled at the acceptance edge
    logic             vld_p0;
    port_t            tag_p0;
    logic [WIDTH-1:0] data_p0;

    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= rd;
    end

    always_ff @(posedge clk) begin
        tag_p0  <= sel_tag;
        data_p0 <= hit ? mem[sel_addr[AW-1:0]] : '0;
    end

    logic             pipe_vld;
    port_t            pipe_tag;
    logic [WIDTH-1:0] pipe_data;

    read_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_read_pipe (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld_p0),
        .tag      (tag_p0),
        .data     (data_p0),
        .dly_vld  (pipe_vld),
        .dly_tag  (pipe_tag),
        .dly_data (pipe_data)
    );

    // Output: last returned word per port is held until that port's next return
    logic [WIDTH-1:0] instr_q, data_q;

    assign instr_valid = pipe_vld && (pipe_tag == PORT_INSTR);
    assign data_valid  = pipe_vld && (pipe_tag == PORT_DATA);
    assign instr       = instr_valid ? pipe_data : instr_q;
    assign data_out    = data_valid  ? pipe_data : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            if (instr_valid) instr_q <= pipe_data;
            if (data_valid)  data_q  <= pipe_data;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) addr_err <= 1'b0;
        else     addr_err <= acc & ~hit;
    end
`endif

endmodule

// File: tb/tb_pipelined_memory.sv
// Scoreboard bench: LATENCY 1, 3 and 4 instances share one stimulus stream and one memory model.
// Compile with MEM_RANGE_CHECK_EN defined to also check addr_err.
`timescale 1ns/1ps
module tb_pipelined_memory;

    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int ND = 3;

    typedef struct {
        int           due;
        bit           is_data;
        logic [W-1:0] val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc = '0, data_addr = '0, data_in = '0;
    logic         instr_req = 1'b0, data_req = 1'b0, write_en = 1'b0;

    logic         ir   [ND];
    logic         iv   [ND];
    logic         dv   [ND];
    logic [W-1:0] io   [ND];
    logic [W-1:0] dout [ND];
`ifdef MEM_RANGE_CHECK_EN
    logic         ae   [ND];
`endif

    exp_t         sb [ND][$];
    int           err_q [$];
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] last_i [ND];
    logic [W-1:0] last_d [ND];

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    logic rst_q  = 1'b0;
    bit   armed  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        rst_q  <= rst;
    end

    pipelined_memory #(.WIDTH(W), .DEPTH(D), .LATENCY(1)) u_dut_l1 (
`ifdef MEM_RANGE_CHECK_EN
        .addr_err(ae[0]),
`endif
        .clk(clk), .rst(rst), .pc(pc), .instr_req(instr_req), .instr_ready(ir[0]),
        .instr(io[0]), .instr_valid(iv[0]), .data_addr(data_addr), .data_req(data_req),
        .write_en(write_en), .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0])
    );

    pipelined_memory #(.WIDTH(W), .DEPTH(D), .LATENCY(3)) u_dut_l3 (
`ifdef MEM_RANGE_CHECK_EN
        .addr_err(ae[1]),
`endif
        .clk(clk), .rst(rst), .pc(pc), .instr_req(instr_req), .instr_ready(ir[1]),
        .instr(io[1]), .instr_valid(iv[1]), .data_addr(data_addr), .data_req(data_req),
        .write_en(write_en), .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1])
    );

    pipelined_memory #(.WIDTH(W), .DEPTH(D), .LATENCY(4)) u_dut_l4 (
`ifdef MEM_RANGE_CHECK_EN
        .addr_err(ae[2]),
`endif
        .clk(clk), .rst(rst), .pc(pc), .instr_req(instr_req), .instr_ready(ir[2]),
        .instr(io[2]), .instr_valid(iv[2]), .data_addr(data_addr), .data_req(data_req),
        .write_en(write_en), .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    function automatic logic [W-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return W'($urandom_range(D, 65535));
        return W'($urandom_range(0, 63));
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d (LATENCY=%0d) edge %0d: got %h, expected %h",
                     name, d, lat_of(d), edge_n, act, exp);
        end
    endtask

    task automatic push_all(input bit is_data, input logic [W-1:0] val);
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.due     = edge_n + lat_of(d);
            e.is_data = is_data;
            e.val     = val;
            sb[d].push_back(e);
        end
    endtask

    function automatic logic [W-1:0] model_read(input logic [W-1:0] a);
        return (a < W'(D)) ? ref_mem[a[9:0]] : '0;
    endfunction

    // Present one cycle of inputs, update the model for the coming edge, then advance.
    task automatic drive(input logic r, input logic ireq, input logic [W-1:0] p,
                         input logic dreq, input logic we, input logic [W-1:0] a,
                         input logic [W-1:0] din);
        exp_t keep [$];
        int   keep_err [$];
        rst = r; instr_req = ireq; pc = p;
        data_req = dreq; write_en = we; data_addr = a; data_in = din;
        if (r) begin
            // Anything due at or after this edge dies with the reset.
            for (int d = 0; d < ND; d++) begin
                keep = {};
                foreach (sb[d][j]) if (sb[d][j].due <= edge_n) keep.push_back(sb[d][j]);
                sb[d] = keep;
            end
            keep_err = {};
            foreach (err_q[j]) if (err_q[j] <= edge_n) keep_err.push_back(err_q[j]);
            err_q = keep_err;
        end else if (dreq) begin
            if (a >= W'(D)) err_q.push_back(edge_n + 1);
            if (we) begin
                if (a < W'(D)) ref_mem[a[9:0]] = din;
            end else begin
                push_all(1'b1, model_read(a));
            end
        end else if (ireq) begin
            if (p >= W'(D)) err_q.push_back(edge_n + 1);
            push_all(1'b0, model_read(p));
        end
        #1;
        for (int d = 0; d < ND; d++) check("instr_ready", d, 32'(ir[d]), 32'(ireq & ~dreq));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: every cycle after reset, compare each instance against its queue.
    initial begin
        exp_t e;
        bit   ae_exp;
        forever begin
            @(negedge clk);
            if (rst_q) armed = 1'b1;
            if (armed) begin
                ae_exp = (err_q.size() > 0 && err_q[0] == edge_n);
                if (ae_exp) void'(err_q.pop_front());
                for (int d = 0; d < ND; d++) begin
                    if (rst_q) begin
                        last_i[d] = '0;
                        last_d[d] = '0;
                    end
                    check("both_valid", d, 32'(iv[d] & dv[d]), 32'd0);
                    if (iv[d] || dv[d]) begin
                        if (sb[d].size() == 0) begin
                            check("spurious_valid", d, 32'(iv[d] | dv[d]), 32'd0);
                        end else begin
                            e = sb[d].pop_front();
                            check("arrival_edge", d, 32'(edge_n), 32'(e.due));
                            check("port_tag", d, 32'(dv[d]), 32'(e.is_data));
                            if (e.is_data) last_d[d] = e.val;
                            else           last_i[d] = e.val;
                        end
                    end else if (sb[d].size() > 0 && sb[d][0].due <= edge_n) begin
                        e = sb[d].pop_front();
                        check("missing_valid", d, 32'(iv[d] | dv[d]), 32'd1);
                    end
                    check("instr", d, 32'(io[d]), 32'(last_i[d]));
                    check("data_out", d, 32'(dout[d]), 32'(last_d[d]));
`ifdef MEM_RANGE_CHECK_EN
                    check("addr_err", d, 32'(ae[d]), 32'(ae_exp));
`endif
                end
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 64; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, W'(i), W'($urandom));

        // Write then read back next cycle.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'd5, 16'hBEEF);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'd5, '0);
        idle(5);

        // Back-to-back fetch stream.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, W'(i), 1'b0, 1'b0, '0, '0);
        idle(5);

        // Contention: data read wins, fetch accepted a cycle later.
        drive(1'b0, 1'b1, 16'd2, 1'b1, 1'b0, 16'd9, '0);
        drive(1'b0, 1'b1, 16'd2, 1'b0, 1'b0, '0, '0);
        idle(5);

        // Out-of-range write is dropped; out-of-range read returns zero.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'd1024, 16'h1234);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'd1024, '0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'd0, '0);
        idle(5);

        // Reset kills in-flight reads; contents survive.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'd5, '0);
        drive(1'b0, 1'b1, 16'd7, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        idle(5);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'd5, '0);
        drive(1'b0, 1'b1, 16'd7, 1'b0, 1'b0, '0, '0);
        idle(5);

        // Write attempted under reset must not land.
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 16'd3, 16'hFFFF);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'd3, '0);
        idle(5);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 2)
                drive(1'b1, 1'($urandom), rand_addr(), 1'($urandom), 1'($urandom), rand_addr(), W'($urandom));
            else
                drive(1'b0, 1'($urandom), rand_addr(), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 2) == 0), rand_addr(), W'($urandom));
        end

        idle(8);
        @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) check("scoreboard_drained", d, 32'(sb[d].size()), 32'd0);
`ifdef MEM_RANGE_CHECK_EN
        check("addr_err_drained", 0, 32'(err_q.size()), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
